pipeline_hazard_ctrl: RTL

Parametrised hazard-detection and forwarding controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Keeps an internal shadow pipeline of destination-register info for EX, MEM and WB.
- Drives stall/flush/PC-write to the pipeline registers and registered forwarding selects to the EX operand muxes.
- Replaces whole-pipeline stalling on every RAW hazard with forwarding plus load-use-only stalls, compile-time selectable.

---
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection and forwarding control for a 5-stage
// IF/ID/EX/MEM/WB pipeline.
// A shadow copy of destination-register info for the EX, MEM and WB stages is
// compared against the source registers of the instruction in ID.
// stall/flush/pc_write are combinational, and the forward selects are registered.
// The selects line up with the instruction as it enters EX.
// Compile-time option: define HAZARD_FWD_EN to enable the forwarding paths.
// With it defined, only load-use hazards stall. Without it, every RAW hazard
// against EX/MEM stalls, and so do hazards against WB when RF_BYPASS=0.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_is_load,
  input  logic                  redirect,
  output logic                  stall,
  output logic                  flush,
  output logic                  pc_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  // One shadow pipeline entry: destination info of an in-flight instruction.
  typedef struct packed {
    logic                  v;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_load;
  } shadow_t;

  localparam logic       NO_BYP_C  = (RF_BYPASS == 0) ? 1'b1 : 1'b0;
  localparam logic [1:0] SEL_ID_C  = 2'd0;
  localparam logic [1:0] SEL_MEM_C = 2'd1;
  localparam logic [1:0] SEL_WB_C  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  // A valid writer of a non-zero register that equals the register being read.
  // Register $0 never produces a hazard.
  function automatic logic match_f(input shadow_t e,
                                   input logic [REG_ADDR_W-1:0] r,
                                   input logic use_r);
    return use_r & e.v & e.wr_en & (e.addr != {REG_ADDR_W{1'b0}}) & (e.addr == r);
  endfunction

  shadow_t          s0_r, s1_r, s2_r;
  shadow_t          s0_nxt_s;
  logic [1:0]       fwd_a_sel_r, fwd_b_sel_r;
  logic [1:0]       fwd_a_nxt_s, fwd_b_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             m0_a_s, m1_a_s, m2_a_s;
  logic             m0_b_s, m1_b_s, m2_b_s;
  logic             stall_cond_s;
  logic             stall_s;
  logic             flush_s;
  logic             bubble_s;
  logic             unused_ok_s;

  // Per-operand match of the ID sources against each shadow stage.
  always_comb begin
    m0_a_s = match_f(s0_r, id_rs, id_uses_rs);
    m1_a_s = match_f(s1_r, id_rs, id_uses_rs);
    m2_a_s = match_f(s2_r, id_rs, id_uses_rs);
    m0_b_s = match_f(s0_r, id_rt, id_uses_rt);
    m1_b_s = match_f(s1_r, id_rt, id_uses_rt);
    m2_b_s = match_f(s2_r, id_rt, id_uses_rt);
  end

  // Raw stall condition before qualification by valid/redirect/reset.
  always_comb begin
    stall_cond_s = 1'b0;
`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time.
    stall_cond_s = ((m0_a_s | m0_b_s) & s0_r.is_load)
                 | (NO_BYP_C & (m2_a_s | m2_b_s));
`else
    stall_cond_s = m0_a_s | m0_b_s | m1_a_s | m1_b_s
                 | (NO_BYP_C & (m2_a_s | m2_b_s));
`endif
  end

  // Pipeline control: redirect outranks stall, and reset silences both.
  always_comb begin
    stall_s  = id_valid & stall_cond_s & ~redirect & ~rst;
    flush_s  = redirect & ~rst;
    bubble_s = redirect | stall_s | ~id_valid;
  end

  // Next EX shadow entry and the forward selects for the instruction entering EX.
  always_comb begin
    s0_nxt_s    = '{v: 1'b0, wr_en: 1'b0, addr: {REG_ADDR_W{1'b0}}, is_load: 1'b0};
    fwd_a_nxt_s = SEL_ID_C;
    fwd_b_nxt_s = SEL_ID_C;
    if (bubble_s) begin
      s0_nxt_s = '{v: 1'b0, wr_en: 1'b0, addr: {REG_ADDR_W{1'b0}}, is_load: 1'b0};
    end else begin
      s0_nxt_s = '{v: 1'b1, wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};
    end
`ifdef HAZARD_FWD_EN
    // The youngest producer wins, so check EX before MEM.
    if (bubble_s) begin
      fwd_a_nxt_s = SEL_ID_C;
      fwd_b_nxt_s = SEL_ID_C;
    end else begin
      if (m0_a_s) begin
        fwd_a_nxt_s = SEL_MEM_C;
      end else if (m1_a_s) begin
        fwd_a_nxt_s = SEL_WB_C;
      end else begin
        fwd_a_nxt_s = SEL_ID_C;
      end
      if (m0_b_s) begin
        fwd_b_nxt_s = SEL_MEM_C;
      end else if (m1_b_s) begin
        fwd_b_nxt_s = SEL_WB_C;
      end else begin
        fwd_b_nxt_s = SEL_ID_C;
      end
    end
`else
    fwd_a_nxt_s = SEL_ID_C;
    fwd_b_nxt_s = SEL_ID_C;
`endif
  end

  // Shadow pipeline advance and registered forward selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_r        <= '{v: 1'b0, wr_en: 1'b0, addr: {REG_ADDR_W{1'b0}}, is_load: 1'b0};
      s1_r        <= '{v: 1'b0, wr_en: 1'b0, addr: {REG_ADDR_W{1'b0}}, is_load: 1'b0};
      s2_r        <= '{v: 1'b0, wr_en: 1'b0, addr: {REG_ADDR_W{1'b0}}, is_load: 1'b0};
      fwd_a_sel_r <= SEL_ID_C;
      fwd_b_sel_r <= SEL_ID_C;
    end else begin
      s0_r        <= s0_nxt_s;
      s1_r        <= s0_r;
      s2_r        <= s1_r;
      fwd_a_sel_r <= fwd_a_nxt_s;
      fwd_b_sel_r <= fwd_b_nxt_s;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX_C)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // The load flag only matters while an entry sits in EX.
  assign unused_ok_s = ^{s0_r.is_load, s1_r.is_load, s2_r.is_load, m1_a_s, m1_b_s};

  assign stall     = stall_s;
  assign flush     = flush_s;
  assign pc_write  = ~stall_s;
  assign fwd_a_sel = fwd_a_sel_r;
  assign fwd_b_sel = fwd_b_sel_r;
  assign stall_cnt = stall_cnt_r;

endmodule
